// File: rtl/histogram_mask_builder.sv
// Per-frame intensity histogram that emits a bin-occupancy mask (count >= min_count) at end of frame.
// Optional macro HIST_OVF_FLAG_EN adds a sticky saturation flag output `ovf`.
module histogram_mask_builder #(
  parameter int unsigned Width = 256,
  parameter int unsigned PixW  = $clog2(Width),
  parameter int unsigned CntW  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [PixW-1:0]  pix,
  input  logic             pix_valid,
  output logic             pix_ready,
  input  logic             pix_sof,
  input  logic             pix_eof,
  input  logic [CntW-1:0]  min_count,
  output logic [Width-1:0] mask,
  output logic             mask_valid
`ifdef HIST_OVF_FLAG_EN
  ,
  output logic             ovf
`endif
);

  localparam logic [CntW-1:0] CntMax = '1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCUM,
    S_EMIT,
    S_CLEAR
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;

  logic [CntW-1:0]   r_cnt [Width];
  logic [Width-1:0]  r_mask;
  logic              r_mask_valid;
  logic              r_pix_ready;

  logic              w_xfer;
  logic              w_count;
  logic              w_restart;
  logic              w_emit;
  logic              w_clear;
  logic              w_ready_nxt;
  logic [CntW-1:0]   w_cur;
  logic [CntW-1:0]   w_new;

  assign w_xfer = pix_valid & r_pix_ready;

  // State register
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_xfer && pix_sof) w_state_nxt = pix_eof ? S_EMIT : S_ACCUM;
      end
      S_ACCUM: begin
        if (w_xfer && pix_eof) w_state_nxt = S_EMIT;
      end
      S_EMIT:  w_state_nxt = S_CLEAR;
      S_CLEAR: w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Decoded controls; ready is precomputed from the next state so the port stays registered
  always_comb begin
    w_count     = 1'b0;
    w_restart   = 1'b0;
    w_emit      = 1'b0;
    w_clear     = 1'b0;
    w_ready_nxt = 1'b0;
    w_count     = w_xfer && ((r_state == S_ACCUM) || ((r_state == S_IDLE) && pix_sof));
    w_restart   = w_count && pix_sof;
    w_emit      = (r_state == S_EMIT);
    w_clear     = (r_state == S_CLEAR);
    w_ready_nxt = (w_state_nxt == S_IDLE) || (w_state_nxt == S_ACCUM);
  end

  // Saturating increment of the addressed bin; a restart begins the bin at 1
  always_comb begin
    w_cur = r_cnt[pix];
    w_new = w_cur;
    if (w_restart)            w_new = CntW'(1);
    else if (w_cur != CntMax) w_new = w_cur + CntW'(1);
  end

  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < Width; i++) begin
      if (rst || w_clear)                       r_cnt[i] <= '0;
      else if (w_count && (pix == PixW'(i)))    r_cnt[i] <= w_new;
      else if (w_restart)                       r_cnt[i] <= '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_mask       <= '0;
      r_mask_valid <= 1'b0;
      r_pix_ready  <= 1'b1;
    end else begin
      r_mask_valid <= w_emit;
      r_pix_ready  <= w_ready_nxt;
      if (w_emit) begin
        for (int unsigned i = 0; i < Width; i++) r_mask[i] <= (r_cnt[i] >= min_count);
      end
    end
  end

  assign pix_ready  = r_pix_ready;
  assign mask       = r_mask;
  assign mask_valid = r_mask_valid;

`ifdef HIST_OVF_FLAG_EN
  logic r_ovf_sticky;
  logic r_ovf;

  // Sticky per-frame saturation tracker, published alongside the mask
  always_ff @(posedge clk) begin
    if (rst || w_clear)                     r_ovf_sticky <= 1'b0;
    else if (w_restart)                     r_ovf_sticky <= (w_new == CntMax);
    else if (w_count && (w_new == CntMax))  r_ovf_sticky <= 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst)         r_ovf <= 1'b0;
    else if (w_emit) r_ovf <= r_ovf_sticky;
  end

  assign ovf = r_ovf;
`endif

endmodule
